max7219_driver: RTL and testbench
=================================

// Module: max7219_driver
// PURPOSE
//   Serial back-end for the calculator display.
//   - On reset release, sends the MAX7219 init sequence.
//   - On each update request, shifts all 8 digit registers out over the 3-wire
//     MAX7219 interface (SCK/CS/DIN).
//   - Sits directly downstream of the calculator fsm: the fsm supplies 8 Code-B
//     nibbles plus an update strobe; this block owns max_sck/max_cs/max_din.
// PARAMETERS
//   CLK_DIV    4     clock cycles per SCK half-period (>=1)
//   INTENSITY  4'h8  value written to the MAX7219 intensity register (0x0A)
// PORTS
//   clock      in   1   system clock (clock_fast domain)
//   reset      in   1   asynchronous, active-high reset
//   digits_in  in   32  nibble i = [4i+3:4i] -> digit register i+1 (Code B)
//   update     in   1   1-cycle request to refresh all 8 digits
//   busy       out  1   high while the init sequence or a frame is in progress
//   max_sck    out  1   serial clock; idle low
//   max_cs     out  1   chip select, active low; rising edge latches the word
//   max_din    out  1   serial data, MSB first
// BEHAVIOUR
//   Reset values (asserted, async): max_cs=1, max_sck=0, max_din=0, busy=1,
//   pending=0, state=INIT.
//
//   Word transfer: 16 bits, {addr[7:0], data[7:0]}.
//   - cs falls; din = bit15; sck stays low for CLK_DIV cycles.
//   - sck high for CLK_DIV cycles, then low; din updates with the falling edge.
//   - Repeat for 16 bits; din is never changed while sck is high.
//   - After the 16th high phase: sck low for CLK_DIV cycles, then cs rises.
//   - cs then stays high for CLK_DIV cycles before the next word.
//   - Word period = 34*CLK_DIV cycles, exactly 16 rising edges per cs-low window.
//
//   FSM states: INIT -> IDLE <-> FRAME, with WORD as a sub-sequencer (bit cnt 0..15,
//   half-period cnt 0..CLK_DIV-1).
//   - INIT: words in order 0x0C01 (normal operation), 0x0F00 (test off),
//     0x0B07 (scan 8), 0x09FF (Code-B all), 0x0A0 & INTENSITY.
//     Then IDLE; busy falls in the first IDLE cycle.
//   - IDLE: busy=0. update=1 -> latch digits_in into shadow reg, go to FRAME,
//     busy=1 on the next cycle.
//   - FRAME: 8 words, addr 0x01..0x08, data = {4'h0, shadow nibble}.
//     Then IDLE, or a new FRAME if pending.
//
//   Update handling and boundary conditions:
//   - update while busy: sets pending and overwrites the shadow-next register
//     with digits_in; last request wins. The frame in progress is unaffected.
//   - End of frame with pending=1: clear pending, load shadow from shadow-next,
//     start the next FRAME with no IDLE cycle (busy stays 1).
//   - update during INIT: also queued as pending; frame follows init.
//   - update in the same cycle a frame ends: treated as pending (no loss).
//   - reset mid-word: cs high and sck low immediately; init restarts on release
//     and pending is discarded.
//   - Latency: update in IDLE -> cs falls 1 cycle later.
//   - Full frame = 8*34*CLK_DIV cycles; init = 5*34*CLK_DIV cycles.
//   - Code B nibble meaning, as decoded by the MAX7219: 0-9 digits,
//     A '-', B 'E', C 'H', D 'L', E 'P', F blank.
// TESTING
//   1 Release reset, CLK_DIV=4 -> decoded words 0C01,0F00,0B07,09FF,0A08;
//     busy falls 680 cycles after release.
//   2 IDLE, digits_in=32'h76543210, update pulse -> words 0100,0201,...,0807;
//     cs falls 1 cycle after update; busy low 1088 cycles later.
//   3 Two updates during a frame (0x11111111, then 0x22222222) -> exactly one
//     follow-up frame carrying 0x02 nibbles; busy never drops between frames.
//   4 Reset asserted mid-bit (bit 7 of word 3) -> cs=1, sck=0, din=0 in the same
//     cycle; full init replays after release; no stale frame is sent.
//   5 Protocol checker, any CLK_DIV -> exactly 16 sck rises per cs-low window;
//     din stable while sck high; cs-high gap >= CLK_DIV cycles.
//   6 CLK_DIV=1 -> init word period 34 cycles; frame content matches scenario 2.

Source files
------------

// File: rtl/max7219_driver.sv
// MAX7219 3-wire serial back-end: sends the init sequence after reset, then
// streams all 8 Code-B digit registers whenever an update is requested.
module max7219_driver #(
  parameter int         CLK_DIV   = 4,
  parameter logic [3:0] INTENSITY = 4'h8
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] digits_in,
  input  logic        update,
  output logic        busy,
  output logic        max_sck,
  output logic        max_cs,
  output logic        max_din
);

  typedef enum logic [1:0] {INIT = 2'd0, IDLE = 2'd1, FRAME = 2'd2} state_e;

  localparam int              DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [5:0]      PH_LAST  = 6'd33;

  state_e             state_q, state_d;
  logic [2:0]         word_q, word_d;
  logic [5:0]         phase_q, phase_d;
  logic [DIV_W-1:0]   div_q, div_d;
  logic               pending_q, pending_d;
  logic               busy_q, busy_d;
  logic               sck_q, sck_d;
  logic               cs_q, cs_d;
  logic               din_q, din_d;
  logic [31:0]        shadow_q, shadow_d;
  logic [31:0]        nxt_q, nxt_d;
  logic               last_pos;

  function automatic logic [15:0] word_val(input state_e st, input logic [2:0] idx,
                                           input logic [31:0] shadow);
    logic [15:0] w;
    w = 16'h0000;
    if (st == INIT) begin
      case (idx)
        3'd0:    w = 16'h0C01;
        3'd1:    w = 16'h0F00;
        3'd2:    w = 16'h0B07;
        3'd3:    w = 16'h09FF;
        3'd4:    w = {8'h0A, 4'h0, INTENSITY};
        default: w = 16'h0000;
      endcase
    end else begin
      w = {4'h0, {1'b0, idx} + 4'd1, 4'h0, shadow[{idx, 2'b00} +: 4]};
    end
    return w;
  endfunction

  // Phase 0: cs low/sck low; odd phases up to 31: sck high; 32: trailing low; 33: cs-high gap.
  function automatic logic [2:0] pins(input state_e st, input logic [2:0] idx,
                                      input logic [5:0] phase, input logic [31:0] shadow);
    logic [15:0] w;
    logic [3:0]  bitn;
    if (st == IDLE || phase == PH_LAST) return 3'b010;
    w    = word_val(st, idx, shadow);
    bitn = (phase >= 6'd32) ? 4'd0 : 4'd15 - phase[4:1];
    return {phase[0], 1'b0, w[bitn]};
  endfunction

  always_comb begin
    state_d   = state_q;
    word_d    = word_q;
    phase_d   = phase_q;
    div_d     = div_q;
    pending_d = pending_q;
    shadow_d  = shadow_q;
    nxt_d     = nxt_q;
    last_pos  = (phase_q == PH_LAST) && (div_q == DIV_LAST);

    // Counters park at the last position of word 7 while idle, so one step starts a word.
    if (state_q != IDLE || update) begin
      if (div_q == DIV_LAST) begin
        div_d = '0;
        if (phase_q == PH_LAST) begin
          phase_d = 6'd0;
          word_d  = word_q + 3'd1;
        end else begin
          phase_d = phase_q + 6'd1;
        end
      end else begin
        div_d = div_q + DIV_W'(1);
      end
    end

    case (state_q)
      IDLE: begin
        if (update) begin
          state_d  = FRAME;
          shadow_d = digits_in;
        end
      end
      INIT, FRAME: begin
        if (update) begin
          pending_d = 1'b1;
          nxt_d     = digits_in;
        end
        if (last_pos && word_q == ((state_q == INIT) ? 3'd4 : 3'd7)) begin
          if (pending_q || update) begin
            state_d   = FRAME;
            word_d    = 3'd0;
            pending_d = 1'b0;
            shadow_d  = update ? digits_in : nxt_q;
          end else begin
            state_d = IDLE;
            word_d  = 3'd7;
            phase_d = PH_LAST;
            div_d   = DIV_LAST;
          end
        end
      end
      default: state_d = INIT;
    endcase

    busy_d = (state_d != IDLE);
    {sck_d, cs_d, din_d} = pins(state_d, word_d, phase_d, shadow_d);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= INIT;
      word_q    <= 3'd7;
      phase_q   <= PH_LAST;
      div_q     <= DIV_LAST;
      pending_q <= 1'b0;
      busy_q    <= 1'b1;
      sck_q     <= 1'b0;
      cs_q      <= 1'b1;
      din_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      word_q    <= word_d;
      phase_q   <= phase_d;
      div_q     <= div_d;
      pending_q <= pending_d;
      busy_q    <= busy_d;
      sck_q     <= sck_d;
      cs_q      <= cs_d;
      din_q     <= din_d;
    end
  end

  always_ff @(posedge clock) begin
    shadow_q <= shadow_d;
    nxt_q    <= nxt_d;
  end

  assign busy    = busy_q;
  assign max_sck = sck_q;
  assign max_cs  = cs_q;
  assign max_din = din_q;

endmodule

// File: tb/tb_max7219_driver.sv
// Bench for max7219_driver: CLK_DIV=4 and CLK_DIV=1 instances share stimulus;
// a serial decoder per instance captures words and protocol flags.
module tb_max7219_driver;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] digits_in = 32'h0;
  logic        update = 1'b0;
  logic        busy4, sck4, cs4, din4;
  logic        busy1, sck1, cs1, din1;

  always #5 clock = ~clock;

  max7219_driver #(.CLK_DIV(4), .INTENSITY(4'h8)) dut4 (
    .clock(clock), .reset(reset), .digits_in(digits_in), .update(update),
    .busy(busy4), .max_sck(sck4), .max_cs(cs4), .max_din(din4));

  max7219_driver #(.CLK_DIV(1), .INTENSITY(4'h8)) dut1 (
    .clock(clock), .reset(reset), .digits_in(digits_in), .update(update),
    .busy(busy1), .max_sck(sck1), .max_cs(cs1), .max_din(din1));

  typedef struct { logic [15:0] word; int rises; bit din_ok; bit gap_ok; } rec_t;
  typedef struct packed { logic [31:0] digits; logic [127:0] exp; } vec_t;

  rec_t q4[$];
  rec_t q1[$];
  int   nvec = 0;
  int   nerr = 0;

  // Serial decoder, sampled on the falling clock edge (outputs move on the rising edge).
  logic [1:0]  m_s, m_c, m_d;
  logic        ps[2], pc[2], pd[2];
  logic [15:0] sh[2];
  int          rs[2], gp[2];
  bit          dok[2], gok[2];
  assign m_s = {sck1, sck4};
  assign m_c = {cs1, cs4};
  assign m_d = {din1, din4};

  always @(negedge clock) begin
    for (int i = 0; i < 2; i++) begin
      if (reset) begin
        ps[i] <= 1'b0; pc[i] <= 1'b1; pd[i] <= 1'b0; sh[i] <= 16'h0;
        rs[i] <= 0; gp[i] <= 100; dok[i] <= 1'b1; gok[i] <= 1'b1;
      end else begin
        ps[i] <= m_s[i]; pc[i] <= m_c[i]; pd[i] <= m_d[i];
        if (!m_c[i]) begin
          if (pc[i]) begin
            rs[i] <= 0; dok[i] <= 1'b1; gok[i] <= (gp[i] >= ((i == 0) ? 4 : 1));
          end else begin
            if (m_s[i] && !ps[i]) begin
              sh[i] <= {sh[i][14:0], m_d[i]};
              rs[i] <= rs[i] + 1;
            end
            if (m_s[i] && ps[i] && m_d[i] != pd[i]) dok[i] <= 1'b0;
          end
        end else begin
          if (!pc[i]) begin
            gp[i] <= 1;
            if (i == 0) q4.push_back(rec_t'{sh[0], rs[0], dok[0], gok[0]});
            else        q1.push_back(rec_t'{sh[1], rs[1], dok[1], gok[1]});
          end else begin
            gp[i] <= gp[i] + 1;
          end
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_word(input string name, input bit which, input logic [15:0] exp);
    rec_t r;
    if ((which ? q1.size() : q4.size()) == 0) begin
      nvec++; nerr++;
      $display("FAIL %s: no word captured, expected %h", name, exp);
      return;
    end
    r = which ? q1.pop_front() : q4.pop_front();
    chk(name, {16'h0, r.word}, {16'h0, exp});
    chk({name, " sck rises"}, r.rises, 16);
    chk({name, " din stable"}, {31'h0, r.din_ok}, 1);
    chk({name, " cs gap"}, {31'h0, r.gap_ok}, 1);
  endtask

  task automatic check_frame(input string tag, input bit which, input logic [127:0] exp);
    for (int k = 0; k < 8; k++)
      chk_word($sformatf("%s d%0d word%0d", tag, which ? 1 : 4, k), which, exp[127-16*k -: 16]);
  endtask

  task automatic measure_init(input string tag);
    logic [15:0] iw [5];
    int c, f4, b4, f1a, f1b, b1;
    logic pc1;
    iw = '{16'h0C01, 16'h0F00, 16'h0B07, 16'h09FF, 16'h0A08};
    c = 0; f4 = -1; b4 = -1; f1a = -1; f1b = -1; b1 = -1; pc1 = 1'b1;
    while (b4 < 0 && c < 3000) begin
      @(posedge clock); #1; c++;
      if (f4 < 0 && !cs4) f4 = c;
      if (b4 < 0 && !busy4) b4 = c;
      if (pc1 && !cs1) begin
        if (f1a < 0) f1a = c;
        else if (f1b < 0) f1b = c;
      end
      if (b1 < 0 && !busy1) b1 = c;
      pc1 = cs1;
    end
    chk({tag, " d4 init length"}, b4 - f4, 680);
    chk({tag, " d1 word period"}, f1b - f1a, 34);
    chk({tag, " d1 init length"}, b1 - f1a, 170);
    for (int k = 0; k < 5; k++) begin
      chk_word($sformatf("%s d4 init%0d", tag, k), 1'b0, iw[k]);
      chk_word($sformatf("%s d1 init%0d", tag, k), 1'b1, iw[k]);
    end
  endtask

  task automatic pulse(input logic [31:0] d);
    @(posedge clock); #1;
    chk("cs idle before update", {31'h0, cs4}, 1);
    digits_in = d; update = 1'b1;
    @(posedge clock); #1;
    update = 1'b0;
    chk("cs falls 1 cycle after update", {31'h0, cs4}, 0);
    chk("busy after update", {31'h0, busy4}, 1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vt [4];
    int   n;
    vt[0] = {32'h76543210, 128'h0100_0201_0302_0403_0504_0605_0706_0807};
    vt[1] = {32'hFEDCBA98, 128'h0108_0209_030A_040B_050C_060D_070E_080F};
    vt[2] = {32'h0000000F, 128'h010F_0200_0300_0400_0500_0600_0700_0800};
    vt[3] = {32'hA5A5A5A5, 128'h0105_020A_0305_040A_0505_060A_0705_080A};

    repeat (3) @(posedge clock);
    #1;
    chk("reset cs", {31'h0, cs4}, 1);
    chk("reset sck", {31'h0, sck4}, 0);
    chk("reset din", {31'h0, din4}, 0);
    chk("reset busy", {31'h0, busy4}, 1);
    chk("reset d1 cs", {31'h0, cs1}, 1);
    @(negedge clock); reset = 1'b0;
    measure_init("boot");

    for (int v = 0; v < 4; v++) begin
      pulse(vt[v].digits);
      n = 0;
      while (busy4 && n < 5000) begin @(posedge clock); #1; n++; end
      chk($sformatf("vec%0d frame length", v), n, 1088);
      check_frame($sformatf("vec%0d", v), 1'b0, vt[v].exp);
      check_frame($sformatf("vec%0d", v), 1'b1, vt[v].exp);
    end

    // Two updates during a frame: only the last one produces a follow-up frame.
    pulse(vt[0].digits);
    n = 0;
    while (busy4 && n < 6000) begin
      if (n == 100)      begin digits_in = 32'h11111111; update = 1'b1; end
      else if (n == 200) begin digits_in = 32'h22222222; update = 1'b1; end
      else update = 1'b0;
      @(posedge clock); #1; n++;
    end
    update = 1'b0;
    chk("pending busy length", n, 2176);
    for (int w = 0; w < 2; w++) begin
      check_frame("pend first", w[0], vt[0].exp);
      check_frame("pend second", w[0], 128'h0102_0202_0302_0402_0502_0602_0702_0802);
    end
    repeat (300) @(posedge clock);
    #1;
    chk("no third frame d4", q4.size(), 0);
    chk("no third frame d1", q1.size(), 0);
    chk("idle after pending", {31'h0, busy4}, 0);

    // Update sampled on the very edge a frame ends.
    pulse(32'h13572468);
    n = 0;
    while (busy4 && n < 6000) begin
      if (n == 1087) begin digits_in = 32'h89ABCDEF; update = 1'b1; end
      else update = 1'b0;
      @(posedge clock); #1; n++;
    end
    update = 1'b0;
    chk("edge update busy length", n, 2176);
    for (int w = 0; w < 2; w++) begin
      check_frame("edge first", w[0], 128'h0108_0206_0304_0402_0507_0605_0703_0801);
      check_frame("edge second", w[0], 128'h010F_020E_030D_040C_050B_060A_0709_0808);
    end

    // Reset mid-bit during init with an update queued; the update must be discarded.
    @(negedge clock); reset = 1'b1;
    repeat (2) @(negedge clock);
    q4.delete(); q1.delete();
    reset = 1'b0;
    n = 0;
    do begin @(posedge clock); #1; n++; end while (cs4 && n < 20);
    chk("init word starts", {31'h0, cs4}, 0);
    for (int k = 1; k <= 477; k++) begin
      if (k == 50) begin digits_in = 32'h44444444; update = 1'b1; end
      else update = 1'b0;
      @(posedge clock); #1;
    end
    chk("pre-reset sck high", {31'h0, sck4}, 1);
    chk("pre-reset din bit7", {31'h0, din4}, 1);
    #1 reset = 1'b1;
    #1;
    chk("mid-bit reset cs", {31'h0, cs4}, 1);
    chk("mid-bit reset sck", {31'h0, sck4}, 0);
    chk("mid-bit reset din", {31'h0, din4}, 0);
    chk("mid-bit reset busy", {31'h0, busy4}, 1);
    repeat (2) @(negedge clock);
    q4.delete(); q1.delete();
    reset = 1'b0;
    measure_init("replay");
    repeat (300) @(posedge clock);
    #1;
    chk("no stale frame busy", {31'h0, busy4}, 0);
    chk("no stale frame d4", q4.size(), 0);
    chk("no stale frame d1", q1.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
